// File: rtl/mult_seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
// Shared definitions for the sequential chunked multiplier:
//   - mult_state_t : controller state encoding (IDLE, CALC, SIGN, DONE)
//   - DEF_*        : default operand and chunk widths
//   - clog2_min1   : index/counter width helper that never returns 0
// -----------------------------------------------------------------------------
package mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } mult_state_t;

    localparam int DEF_A_W  = 32;
    localparam int DEF_B_W  = 32;
    localparam int DEF_A_CH = 8;
    localparam int DEF_B_CH = 16;

    // A counter that only ever holds 0 still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_seq_gen_if.sv
// -----------------------------------------------------------------------------
// mult_seq_gen_if
// Request/response bundle of the sequential multiplier.
//   start       : request a new multiply (master -> slave)
//   signed_mode : 1 = two's-complement operands, sampled with start
//   a, b        : operands, sampled with start
//   busy        : operation in progress (slave -> master)
//   done        : one-cycle pulse, product valid
//   product     : result register, held until the next accepted start
// -----------------------------------------------------------------------------
interface mult_seq_gen_if #(
    parameter int A_W = 32,
    parameter int B_W = 32
);
    logic                 start;
    logic                 signed_mode;
    logic [A_W-1:0]       a;
    logic [B_W-1:0]       b;
    logic                 busy;
    logic                 done;
    logic [A_W+B_W-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_seq_gen_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_gen_ctrl
// FSM and step counter of the sequential multiplier.
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   start      : new-operation request (honoured in IDLE and DONE only)
//   load       : latch operands / clear product this edge
//   calc_en    : accumulate the partial product selected by a_idx/b_idx
//   sign_en    : apply the sign correction this edge
//   busy, done : status (busy in CALC/SIGN, done in DONE)
//   a_idx      : A chunk index  = k mod NA (inner loop)
//   b_idx      : B chunk index  = k div NA (outer loop)
// -----------------------------------------------------------------------------
module mult_seq_gen_ctrl
    import mult_seq_pkg::*;
#(
    parameter int NA   = 4,
    parameter int NB   = 2,
    parameter int IA_W = 2,
    parameter int IB_W = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            load,
    output logic            calc_en,
    output logic            sign_en,
    output logic            busy,
    output logic            done,
    output logic [IA_W-1:0] a_idx,
    output logic [IB_W-1:0] b_idx
);

    localparam int STEPS = NA * NB;
    localparam int CNT_W = clog2_min1(STEPS);

    mult_state_t      state_reg, state_next;
    logic [CNT_W-1:0] k_reg, k_next;
    logic             last_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
        end
    end

    assign last_step = (k_reg == CNT_W'(STEPS - 1));

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        load       = 1'b0;
        calc_en    = 1'b0;
        sign_en    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    k_next     = '0;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                busy    = 1'b1;
                calc_en = 1'b1;
                if (last_step) begin
                    k_next     = '0;
                    state_next = ST_SIGN;
                end else begin
                    k_next = k_reg + CNT_W'(1);
                end
            end
            ST_SIGN: begin
                busy       = 1'b1;
                sign_en    = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                // A start seen here chains straight into the next operation.
                if (start) begin
                    load       = 1'b1;
                    k_next     = '0;
                    state_next = ST_CALC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A chunks form the inner loop, B chunks the outer loop.
    assign a_idx = IA_W'(k_reg % NA);
    assign b_idx = IB_W'(k_reg / NA);

endmodule

// File: rtl/mult_seq_gen.sv
// -----------------------------------------------------------------------------
// mult_seq_gen
// Sequential multiplier: one A_CH x B_CH unsigned partial product per cycle
// over the magnitudes of the operands, followed by a single sign-correction
// cycle. With start taken at one edge, done is high in the cycle that is
// sampled STEPS+2 edges later.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears state, product and sign flag
//   bus   : mult_seq_gen_if slave (start, signed_mode, a, b, busy, done,
//           product)
// -----------------------------------------------------------------------------
module mult_seq_gen
    import mult_seq_pkg::*;
#(
    parameter int A_W  = DEF_A_W,
    parameter int B_W  = DEF_B_W,
    parameter int A_CH = DEF_A_CH,
    parameter int B_CH = DEF_B_CH
) (
    input  logic            clk,
    input  logic            reset,
    mult_seq_gen_if.slave   bus
);

    localparam int NA   = A_W / A_CH;
    localparam int NB   = B_W / B_CH;
    localparam int P_W  = A_W + B_W;
    localparam int PP_W = A_CH + B_CH;
    localparam int IA_W = clog2_min1(NA);
    localparam int IB_W = clog2_min1(NB);

    generate
        if ((A_W % A_CH) != 0) begin : g_bad_a_ch
            $error("mult_seq_gen: A_W must be a multiple of A_CH");
        end
        if ((B_W % B_CH) != 0) begin : g_bad_b_ch
            $error("mult_seq_gen: B_W must be a multiple of B_CH");
        end
    endgenerate

    logic [A_W-1:0]  a_mag_reg;
    logic [B_W-1:0]  b_mag_reg;
    logic            neg_reg;
    logic [P_W-1:0]  product_reg;

    logic            load, calc_en, sign_en, busy, done;
    logic [IA_W-1:0] a_idx;
    logic [IB_W-1:0] b_idx;

    mult_seq_gen_ctrl #(
        .NA   (NA),
        .NB   (NB),
        .IA_W (IA_W),
        .IB_W (IB_W)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .start   (bus.start),
        .load    (load),
        .calc_en (calc_en),
        .sign_en (sign_en),
        .busy    (busy),
        .done    (done),
        .a_idx   (a_idx),
        .b_idx   (b_idx)
    );

    // Operand magnitudes. Negating the most negative value wraps back onto
    // itself, which read as unsigned is exactly 2^(W-1), so no special case.
    logic [A_W-1:0] a_abs;
    logic [B_W-1:0] b_abs;
    logic           neg_in;

    assign a_abs  = (bus.signed_mode && bus.a[A_W-1]) ? (~bus.a + A_W'(1)) : bus.a;
    assign b_abs  = (bus.signed_mode && bus.b[B_W-1]) ? (~bus.b + B_W'(1)) : bus.b;
    assign neg_in = bus.signed_mode & (bus.a[A_W-1] ^ bus.b[B_W-1]);

    // Chunk views of the latched magnitudes.
    logic [A_CH-1:0] a_chunks [NA];
    logic [B_CH-1:0] b_chunks [NB];

    genvar gi;
    generate
        for (gi = 0; gi < NA; gi++) begin : g_a_chunk
            assign a_chunks[gi] = a_mag_reg[gi*A_CH +: A_CH];
        end
        for (gi = 0; gi < NB; gi++) begin : g_b_chunk
            assign b_chunks[gi] = b_mag_reg[gi*B_CH +: B_CH];
        end
    endgenerate

    logic [A_CH-1:0] a_chunk;
    logic [B_CH-1:0] b_chunk;
    logic [PP_W-1:0] partial;
    logic [31:0]     shift_amt;
    logic [P_W-1:0]  partial_shifted;

    assign a_chunk         = a_chunks[a_idx];
    assign b_chunk         = b_chunks[b_idx];
    assign partial         = PP_W'(a_chunk) * PP_W'(b_chunk);
    assign shift_amt       = 32'(a_idx) * A_CH + 32'(b_idx) * B_CH;
    assign partial_shifted = P_W'(partial) << shift_amt;

    // The magnitude product is below 2^(A_W+B_W), so the running sum never
    // overflows the product register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_mag_reg   <= '0;
            b_mag_reg   <= '0;
            neg_reg     <= 1'b0;
            product_reg <= '0;
        end else if (load) begin
            a_mag_reg   <= a_abs;
            b_mag_reg   <= b_abs;
            neg_reg     <= neg_in;
            product_reg <= '0;
        end else if (calc_en) begin
            product_reg <= product_reg + partial_shifted;
        end else if (sign_en && neg_reg) begin
            product_reg <= ~product_reg + P_W'(1);
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_reg;

endmodule

// File: tb/tb_mult_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_gen
// Two instances: default widths (32x32, chunks 8x16) and a reduced one
// (16x24, chunks 4x8). Expected products come from full-width arithmetic on
// sign- or zero-extended operands, truncated to A_W+B_W bits.
// -----------------------------------------------------------------------------
module tb_mult_seq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_d;
    logic reset_s;

    int n_checks = 0;
    int n_fail   = 0;

    mult_seq_gen_if #(.A_W(32), .B_W(32)) bus_d ();
    mult_seq_gen_if #(.A_W(16), .B_W(24)) bus_s ();

    mult_seq_gen #(.A_W(32), .B_W(32), .A_CH(8), .B_CH(16)) dut_d (
        .clk   (clk),
        .reset (reset_d),
        .bus   (bus_d)
    );

    mult_seq_gen #(.A_W(16), .B_W(24), .A_CH(4), .B_CH(8)) dut_s (
        .clk   (clk),
        .reset (reset_s),
        .bus   (bus_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: extend operands to 64 bits according to signedness, multiply,
    // keep the low aw+bw bits.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input int aw, input int bw, input logic sm);
        logic [63:0] ea, eb, mask;
        ea = a;
        eb = b;
        if (sm && a[aw-1]) ea = a | (~64'd0 << aw);
        if (sm && b[bw-1]) eb = b | (~64'd0 << bw);
        mask = ((aw + bw) >= 64) ? ~64'd0 : ((64'd1 << (aw + bw)) - 64'd1);
        return (ea * eb) & mask;
    endfunction

    // One operation on the default instance: latency counted in falling edges
    // from the one where start is driven to the one where done is seen.
    task automatic run_d(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         input logic [63:0] exp, input string tag);
        int   lat;
        int   busy_n;
        logic got;
        @(negedge clk);
        bus_d.a           = a;
        bus_d.b           = b;
        bus_d.signed_mode = sm;
        bus_d.start       = 1'b1;
        lat    = 0;
        busy_n = 0;
        got    = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            bus_d.start = 1'b0;
            if (lat == 1) begin
                // Operands must already be latched; disturb the inputs.
                bus_d.a           = $urandom;
                bus_d.b           = $urandom;
                bus_d.signed_mode = ~sm;
            end
            if (bus_d.busy === 1'b1) busy_n++;
            got = (bus_d.done === 1'b1);
        end
        check({tag, "/done_seen"}, 64'(got), 64'd1);
        check({tag, "/latency"}, 64'(lat), 64'd10);
        check({tag, "/busy_cycles"}, 64'(busy_n), 64'd9);
        check({tag, "/product"}, bus_d.product, exp);
        @(negedge clk);
        check({tag, "/done_pulse"}, 64'(bus_d.done), 64'd0);
        check({tag, "/hold"}, bus_d.product, exp);
        $display("txn d %s a=%h b=%h sm=%0d product=%h lat=%0d", tag, a, b, sm, bus_d.product, lat);
    endtask

    task automatic run_s(input logic [15:0] a, input logic [23:0] b, input logic sm, input int idx);
        int          lat;
        int          busy_n;
        logic        got;
        logic [63:0] exp;
        exp = ref_mul(64'(a), 64'(b), 16, 24, sm);
        @(negedge clk);
        bus_s.a           = a;
        bus_s.b           = b;
        bus_s.signed_mode = sm;
        bus_s.start       = 1'b1;
        lat    = 0;
        busy_n = 0;
        got    = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            bus_s.start = 1'b0;
            if (bus_s.busy === 1'b1) busy_n++;
            got = (bus_s.done === 1'b1);
        end
        check($sformatf("s%0d/done_seen", idx), 64'(got), 64'd1);
        check($sformatf("s%0d/latency", idx), 64'(lat), 64'd14);
        check($sformatf("s%0d/busy_cycles", idx), 64'(busy_n), 64'd13);
        check($sformatf("s%0d/product", idx), 64'(bus_s.product), exp);
        $display("txn s %0d a=%h b=%h sm=%0d product=%h lat=%0d", idx, a, b, sm, bus_s.product, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, xa, xb;
        logic        rsm;
        logic [63:0] p1, p2;
        int          dn, lat1, lat2, lat, busy_in_done;

        reset_d = 1'b1;
        reset_s = 1'b1;
        bus_d.start = 1'b0; bus_d.signed_mode = 1'b0; bus_d.a = '0; bus_d.b = '0;
        bus_s.start = 1'b0; bus_s.signed_mode = 1'b0; bus_s.a = '0; bus_s.b = '0;
        repeat (3) @(negedge clk);
        check("reset/busy_d", 64'(bus_d.busy), 64'd0);
        check("reset/done_d", 64'(bus_d.done), 64'd0);
        check("reset/product_d", bus_d.product, 64'd0);
        check("reset/busy_s", 64'(bus_s.busy), 64'd0);
        check("reset/done_s", 64'(bus_s.done), 64'd0);
        check("reset/product_s", 64'(bus_s.product), 64'd0);
        reset_d = 1'b0;
        reset_s = 1'b0;
        @(negedge clk);

        // Directed vectors on the default instance.
        run_d(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max");
        run_d(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, "s_m2x3");
        run_d(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minxmin");
        run_d(32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000, "u_msb_x2");
        run_d(32'h8000_0000, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_0000_0000, "s_min_x2");
        run_d(32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 64'h0, "zero");
        for (int i = 0; i < 20; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rsm = 1'($urandom_range(0, 1));
            run_d(ra, rb, rsm, ref_mul(64'(ra), 64'(rb), 32, 32, rsm), $sformatf("rand%0d", i));
        end

        // start pulsed mid-calculation with other operands must be ignored.
        ra = 32'h1234_5678; rb = 32'h9ABC_DEF0; xa = 32'h0F0F_0F0F; xb = 32'h7777_7777;
        @(negedge clk);
        bus_d.a = ra; bus_d.b = rb; bus_d.signed_mode = 1'b0; bus_d.start = 1'b1;
        dn = 0; lat1 = 0; p1 = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus_d.start = 1'b0;
            if (c == 3) begin
                bus_d.a = xa; bus_d.b = xb; bus_d.signed_mode = 1'b1; bus_d.start = 1'b1;
            end
            if (bus_d.done === 1'b1) begin
                dn++;
                if (dn == 1) begin lat1 = c; p1 = bus_d.product; end
            end
        end
        check("ignore/done_count", 64'(dn), 64'd1);
        check("ignore/latency", 64'(lat1), 64'd10);
        check("ignore/product", p1, ref_mul(64'(ra), 64'(rb), 32, 32, 1'b0));
        $display("txn d ignore_start done_count=%0d product=%h", dn, p1);

        // Reset at CALC step 4.
        @(negedge clk);
        bus_d.a = 32'hFFFF_FFFF; bus_d.b = 32'hFFFF_FFFF; bus_d.signed_mode = 1'b0; bus_d.start = 1'b1;
        @(negedge clk);
        bus_d.start = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset/busy_before", 64'(bus_d.busy), 64'd1);
        reset_d = 1'b1;
        #1;
        check("midreset/busy", 64'(bus_d.busy), 64'd0);
        check("midreset/done", 64'(bus_d.done), 64'd0);
        check("midreset/product", bus_d.product, 64'd0);
        $display("txn d mid_reset busy=%0d done=%0d product=%h", bus_d.busy, bus_d.done, bus_d.product);
        @(negedge clk);
        reset_d = 1'b0;
        run_d(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, "after_reset");

        // start held high: back-to-back operations with one DONE cycle between.
        ra = 32'hCAFE_F00D; rb = 32'h0000_1234; xa = 32'h8765_4321; xb = 32'hFFFF_0001;
        @(negedge clk);
        bus_d.a = ra; bus_d.b = rb; bus_d.signed_mode = 1'b0; bus_d.start = 1'b1;
        dn = 0; lat1 = 0; lat2 = 0; p1 = '0; p2 = '0; busy_in_done = 0; lat = 0;
        while (dn < 2 && lat < 60) begin
            @(negedge clk);
            lat++;
            if (bus_d.done === 1'b1) begin
                dn++;
                if (bus_d.busy === 1'b1) busy_in_done++;
                if (dn == 1) begin
                    lat1 = lat; p1 = bus_d.product;
                    bus_d.a = xa; bus_d.b = xb; bus_d.signed_mode = 1'b1;
                end else begin
                    lat2 = lat; p2 = bus_d.product;
                    bus_d.start = 1'b0;
                end
            end
        end
        bus_d.start = 1'b0;
        check("b2b/done_count", 64'(dn), 64'd2);
        check("b2b/first_latency", 64'(lat1), 64'd10);
        check("b2b/second_latency", 64'(lat2), 64'd20);
        check("b2b/busy_in_done", 64'(busy_in_done), 64'd0);
        check("b2b/first_product", p1, ref_mul(64'(ra), 64'(rb), 32, 32, 1'b0));
        check("b2b/second_product", p2, ref_mul(64'(xa), 64'(xb), 32, 32, 1'b1));
        $display("txn d back_to_back p1=%h p2=%h lat1=%0d lat2=%0d", p1, p2, lat1, lat2);

        // Reduced instance: corners then random operands.
        for (int i = 0; i < 1000; i++) begin
            case (i)
                0: run_s(16'h8000, 24'h80_0000, 1'b1, i);
                1: run_s(16'hFFFF, 24'hFF_FFFF, 1'b0, i);
                2: run_s(16'hFFFF, 24'hFF_FFFF, 1'b1, i);
                3: run_s(16'h8000, 24'h00_0001, 1'b1, i);
                default: run_s(16'($urandom), 24'($urandom), 1'($urandom_range(0, 1)), i);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
